// File: rtl/fetch_defs.sv
// Shared constants for the instruction-fetch front-end.
package fetch_defs;

  localparam int ROM_ADDR_WIDTH = 8;
  localparam int INST_WIDTH     = 32;
  localparam int RESET_PC       = 0;

  // Buffer entry layout is {pc, data}: pc in the upper bits, data in the lower.
  localparam int ENTRY_WIDTH    = ROM_ADDR_WIDTH + INST_WIDTH;
  localparam int ENTRY_PC_LSB   = INST_WIDTH;

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry shift FIFO holding fetched {pc, data} words.
// Entry 0 is always the head. Flush clears occupancy only; the stored
// words are left in place so the head output holds its last value.
module fetch_fifo2
  import fetch_defs::*;
#(
  parameter int W = ENTRY_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_head,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_e0;
  logic [W-1:0] r_e1;
  logic [1:0]   r_count;
  logic         w_pop;

  // A pop on an empty buffer is ignored.
  assign w_pop   = i_pop & (r_count != 2'd0);
  assign o_head  = r_e0;
  assign o_count = r_count;

  // Occupancy and storage update; flush wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 2'd0;
      r_e0    <= '0;
      r_e1    <= '0;
    end else if (i_flush) begin
      r_count <= 2'd0;
    end else begin
      case ({i_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_e0 <= i_data;
          else                 r_e1 <= i_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          if (r_count == 2'd2) r_e0 <= r_e1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd2) begin
            r_e0 <= r_e1;
            r_e1 <= i_data;
          end else begin
            r_e0 <= i_data;
          end
        end
        default: begin
          r_count <= r_count;
        end
      endcase
    end
  end

endmodule

// File: rtl/rom_fetch.sv
// Instruction fetch front-end for a synchronous 1-cycle-latency program ROM.
// Handshake: a word transfers to decode on a rising edge where inst_valid
// and inst_ready are both high and redirect_valid is low; inst_data/inst_pc
// are stable while inst_valid is high and not accepted. A redirect flushes
// the buffer and the in-flight read and restarts fetch at redirect_addr.
module rom_fetch
  import fetch_defs::*;
#(
  parameter int                    ADDR_WIDTH = ROM_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = INST_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = ADDR_WIDTH'(RESET_PC)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic [1:0]            dbg_count
);

  localparam int EW = ADDR_WIDTH + DATA_WIDTH;

  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] r_req_pc;
  logic                  r_req_valid;

  logic [1:0]            w_count;
  logic [EW-1:0]         w_head;
  logic                  w_pop;
  logic                  w_issue;
  logic [2:0]            w_occ;

  // Words buffered plus the one in flight; issuing is allowed only if the
  // total after this cycle's pop leaves room for the new request.
  assign w_pop   = inst_valid & inst_ready & ~redirect_valid;
  assign w_occ   = {1'b0, w_count} + {2'b00, r_req_valid};
  assign w_issue = ~redirect_valid & (w_occ < (3'd2 + {2'b00, w_pop}));

  assign rom_addr   = r_fetch_pc;
  assign inst_valid = (w_count != 2'd0);
  assign inst_pc    = w_head[EW-1:DATA_WIDTH];
  assign inst_data  = w_head[DATA_WIDTH-1:0];
  assign dbg_count  = w_count;

  // PC and in-flight request tracking; redirect overrides issue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_pc  <= START_ADDR;
      r_req_pc    <= '0;
      r_req_valid <= 1'b0;
    end else if (redirect_valid) begin
      r_fetch_pc  <= redirect_addr;
      r_req_valid <= 1'b0;
    end else if (w_issue) begin
      r_req_valid <= 1'b1;
      r_req_pc    <= r_fetch_pc;
      r_fetch_pc  <= r_fetch_pc + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r_req_valid <= 1'b0;
    end
  end

  fetch_fifo2 #(
    .W(EW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_flush (redirect_valid),
    .i_push  (r_req_valid),
    .i_pop   (w_pop),
    .i_data  ({r_req_pc, rom_data}),
    .o_head  (w_head),
    .o_count (w_count)
  );

endmodule

// File: tb/tb_rom_fetch.sv
// Bench for rom_fetch: ROM model, per-scenario tasks, {pc,data} scoreboard.
module tb_rom_fetch;

  logic        clk;
  logic        reset_n;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [7:0]  redirect_addr;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [7:0]  inst_pc;
  logic [1:0]  dbg_count;

  logic [39:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  rom_fetch u_dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .dbg_count      (dbg_count)
  );

  // Clock and ROM model (1-cycle read latency)
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= 32'hC0DE0000 | {24'h0, rom_addr};

  // Scoreboard monitor: sampled at negedge, i.e. the values the next edge captures
  always @(negedge clk) begin
    logic [39:0] exp_e;
    if (reset_n) begin
      n_checks++;
      if (dbg_count > 2'd2) begin
        n_fail++;
        $display("FAIL overflow: count=%0d required<=2", dbg_count);
      end
      if (inst_valid && inst_ready && !redirect_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_accept: pc=%h data=%h, no word expected", inst_pc, inst_data);
        end else begin
          exp_e = exp_q.pop_front();
          if ({inst_pc, inst_data} !== exp_e) begin
            n_fail++;
            $display("FAIL accept: got pc=%h data=%h, expected pc=%h data=%h",
                     inst_pc, inst_data, exp_e[39:32], exp_e[31:0]);
          end
        end
      end
    end
  end

  // Driver helpers
  task automatic push_seq(input logic [7:0] start, input int n);
    logic [7:0] pc;
    for (int i = 0; i < n; i++) begin
      pc = start + 8'(i);
      exp_q.push_back({pc, 32'hC0DE0000 | {24'h0, pc}});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold/randomise ready until the scoreboard drains; optionally check cycle count
  task automatic drain(input int exp_cyc, input bit rand_ready, input string name);
    int cyc;
    cyc = 0;
    inst_ready = 1'b1;
    while (exp_q.size() != 0 && cyc < 300) begin
      step();
      cyc++;
      if (rand_ready && exp_q.size() != 0) inst_ready = ($urandom_range(0, 1) == 1);
    end
    inst_ready = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d words still expected", name, exp_q.size());
      exp_q.delete();
    end
    if (exp_cyc > 0) begin
      n_checks++;
      if (cyc != exp_cyc) begin
        n_fail++;
        $display("FAIL %s_cycles: took %0d cycles, expected %0d", name, cyc, exp_cyc);
      end
    end
  endtask

  task automatic check_first(input logic [7:0] pc, input string name);
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== pc || inst_data !== (32'hC0DE0000 | {24'h0, pc})) begin
      n_fail++;
      $display("FAIL %s_first: valid=%b pc=%h data=%h, expected valid=1 pc=%h", name,
               inst_valid, inst_pc, inst_data, pc);
    end
  endtask

  task automatic check_idle(input string name);
    n_checks++;
    if (inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: inst_valid=%b expected 0", name, inst_valid);
    end
  endtask

  // Scenario tasks
  task automatic test_reset();
    reset_n = 1'b0; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_addr = 8'h00;
    #2;
    n_checks++;
    if (inst_valid !== 1'b0 || rom_addr !== 8'h00 || inst_pc !== 8'h00 ||
        inst_data !== 32'h0 || dbg_count !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_values: valid=%b addr=%h pc=%h data=%h count=%0d, expected all 0",
               inst_valid, rom_addr, inst_pc, inst_data, dbg_count);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    push_seq(8'h00, 8);
    step(); check_idle("reset_latency");
    step(); check_first(8'h00, "reset_latency");
    drain(8, 1'b0, "stream");
  endtask

  task automatic test_backpressure();
    repeat (6) step();
    n_checks++;
    if (dbg_count !== 2'd2 || rom_addr !== 8'h0A || inst_pc !== 8'h08) begin
      n_fail++;
      $display("FAIL stall_state: count=%0d addr=%h head=%h, expected 2/0a/08",
               dbg_count, rom_addr, inst_pc);
    end
    push_seq(8'h08, 8);
    drain(8, 1'b0, "release");
  endtask

  task automatic test_random_ready();
    push_seq(8'h10, 20);
    drain(0, 1'b1, "random");
    repeat (3) step();
  endtask

  task automatic test_redirect();
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_addr = 8'h40;
    step();
    redirect_valid = 1'b0;
    n_checks++;
    if (inst_valid !== 1'b0 || rom_addr !== 8'h40 || dbg_count !== 2'd0) begin
      n_fail++;
      $display("FAIL redirect_flush: valid=%b addr=%h count=%0d, expected 0/40/0",
               inst_valid, rom_addr, dbg_count);
    end
    push_seq(8'h40, 8);
    step(); check_idle("redirect_latency");
    step(); check_first(8'h40, "redirect_latency");
    drain(8, 1'b0, "redirect");
    repeat (3) step();
  endtask

  task automatic test_redirect_wrap();
    redirect_valid = 1'b1; redirect_addr = 8'hFE;
    step();
    redirect_valid = 1'b0;
    n_checks++;
    if (inst_valid !== 1'b0 || rom_addr !== 8'hFE || dbg_count !== 2'd0) begin
      n_fail++;
      $display("FAIL wrap_flush: valid=%b addr=%h count=%0d, expected 0/fe/0",
               inst_valid, rom_addr, dbg_count);
    end
    repeat (3) step();
    n_checks++;
    if (dbg_count !== 2'd2 || inst_pc !== 8'hFE || rom_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL wrap_full: count=%0d head=%h addr=%h, expected 2/fe/00",
               dbg_count, inst_pc, rom_addr);
    end
    push_seq(8'hFE, 4);
    drain(4, 1'b0, "wrap");
    repeat (3) step();
  endtask

  task automatic test_redirect_burst();
    inst_ready = 1'b1; redirect_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      redirect_addr = 8'h10 + 8'(i);
      step();
      n_checks++;
      if (inst_valid !== 1'b0 || rom_addr !== (8'h10 + 8'(i))) begin
        n_fail++;
        $display("FAIL burst_%0d: valid=%b addr=%h, expected 0/%h", i, inst_valid,
                 rom_addr, 8'h10 + 8'(i));
      end
    end
    redirect_valid = 1'b0;
    push_seq(8'h13, 4);
    step(); check_idle("burst_latency");
    step(); check_first(8'h13, "burst_latency");
    drain(4, 1'b0, "burst");
  endtask

  task automatic test_reset_mid();
    repeat (3) step();
    n_checks++;
    if (dbg_count !== 2'd2) begin
      n_fail++;
      $display("FAIL pre_reset_full: count=%0d expected 2", dbg_count);
    end
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (inst_valid !== 1'b0 || rom_addr !== 8'h00 || dbg_count !== 2'd0) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b addr=%h count=%0d, expected 0/00/0",
               inst_valid, rom_addr, dbg_count);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    inst_ready = 1'b1;
    push_seq(8'h00, 4);
    step(); check_idle("restart_latency");
    step(); check_first(8'h00, "restart_latency");
    drain(4, 1'b0, "restart");
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_random_ready();
    test_redirect();
    test_redirect_wrap();
    test_redirect_burst();
    test_reset_mid();
    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
